// File: rtl/disp_pkg.sv
// Shared display types and constants for the line buffer datapath.
package disp_pkg;

    localparam int unsigned DISP_DW = 24;
    localparam int unsigned DISP_PW = 12;

    typedef logic [DISP_DW-1:0] pixel_t;
    typedef logic [DISP_PW-1:0] coord_t;

    localparam pixel_t BLACK            = '0;
    localparam pixel_t UNDERRUN_DEFAULT = BLACK;

    typedef enum logic {
        LB_IDLE = 1'b0,
        LB_FILL = 1'b1
    } lb_state_t;

endpackage

// File: rtl/disp_lb_ram.sv
// Two-bank line storage: one write port, one registered read port (1-cycle latency).
module disp_lb_ram #(
    parameter int unsigned DEPTH = 800,
    parameter int unsigned DW    = 24,
    parameter int unsigned XW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [XW-1:0] wr_x,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [XW-1:0] rd_x,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_x] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_bank][rd_x];
    end

endmodule

// File: rtl/disp_line_buffer.sv
// Ping-pong line buffer between the framebuffer reader stream and the display timing driver.
// Optional underrun_cnt statistics port is enabled by defining DISP_LB_STATS_EN.
module disp_line_buffer
    import disp_pkg::*;
#(
    parameter int unsigned   H_DISP         = 800,
    parameter int unsigned   V_DISP         = 480,
    parameter int unsigned   DW             = DISP_DW,
    parameter int unsigned   PW             = DISP_PW,
    parameter logic [DW-1:0] UNDERRUN_COLOR = UNDERRUN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    input  logic [PW-1:0] pixel_hpos,
    input  logic [PW-1:0] pixel_vpos,
    output logic          pixel_valid,
    output logic [DW-1:0] pixel_data,
    output logic          underrun
`ifdef DISP_LB_STATS_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam int unsigned   XW     = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
    localparam logic [PW-1:0] L_LAST = PW'(V_DISP - 1);
    localparam logic [PW-1:0] H_LIM  = PW'(H_DISP);
    localparam logic [PW-1:0] V_LIM  = PW'(V_DISP);

    lb_state_t     state, state_nx;
    logic [1:0]    bank_full, bank_full_nx;
    logic [PW-1:0] bank_line [2];
    logic [XW-1:0] wr_x, wr_x_nx;
    logic [PW-1:0] wr_line, wr_line_nx;
    logic [PW-1:0] vpos_q;

    logic          wr_en, wr_bank, line_done, release_line;
    logic [XW-1:0] wr_addr;
    logic          active, hit;
    logic [DW-1:0] rd_data;

    assign release_line = (pixel_vpos != vpos_q) && (vpos_q < V_LIM);
    assign active       = (pixel_hpos < H_LIM) && (pixel_vpos < V_LIM);
    assign hit          = active && bank_full[pixel_vpos[0]] &&
                          (bank_line[pixel_vpos[0]] == pixel_vpos);

    always_comb begin
        state_nx     = state;
        bank_full_nx = bank_full;
        wr_x_nx      = wr_x;
        wr_line_nx   = wr_line;
        s_ready      = 1'b0;
        wr_en        = 1'b0;
        wr_bank      = 1'b0;
        wr_addr      = '0;
        line_done    = 1'b0;

        if (release_line)
            bank_full_nx[vpos_q[0]] = 1'b0;

        case (state)
            LB_IDLE: begin
                s_ready = !rst && (!s_sof || !bank_full[0]);
                if (s_valid && s_ready && s_sof) begin
                    wr_en      = 1'b1;
                    wr_x_nx    = XW'(1);
                    wr_line_nx = '0;
                    state_nx   = LB_FILL;
                end
            end
            LB_FILL: begin
                s_ready = !rst && !bank_full[wr_line[0]];
                if (s_valid && s_ready) begin
                    wr_en = 1'b1;
                    // (0,0) is never the fill position here, so any sof is a resync
                    if (s_sof) begin
                        bank_full_nx = '0;
                        wr_x_nx      = XW'(1);
                        wr_line_nx   = '0;
                    end else begin
                        wr_bank = wr_line[0];
                        wr_addr = wr_x;
                        if (wr_x == X_LAST) begin
                            bank_full_nx[wr_line[0]] = 1'b1;
                            line_done  = 1'b1;
                            wr_x_nx    = '0;
                            wr_line_nx = wr_line + 1'b1;
                            if (wr_line == L_LAST)
                                state_nx = LB_IDLE;
                        end else begin
                            wr_x_nx = wr_x + 1'b1;
                        end
                    end
                end
            end
            default: state_nx = LB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LB_IDLE;
            bank_full   <= '0;
            wr_x        <= '0;
            wr_line     <= '0;
            vpos_q      <= '1;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            bank_full   <= bank_full_nx;
            wr_x        <= wr_x_nx;
            wr_line     <= wr_line_nx;
            vpos_q      <= pixel_vpos;
            pixel_valid <= hit;
            underrun    <= active && !hit;
        end
    end

    always_ff @(posedge clk) begin
        if (line_done)
            bank_line[wr_line[0]] <= wr_line;
    end

    always_comb begin
        if (pixel_valid)
            pixel_data = rd_data;
        else if (underrun)
            pixel_data = UNDERRUN_COLOR;
        else
            pixel_data = '0;
    end

`ifdef DISP_LB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            underrun_cnt <= '0;
        else if (underrun && (underrun_cnt != '1))
            underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif

    disp_lb_ram #(
        .DEPTH (H_DISP),
        .DW    (DW),
        .XW    (XW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_x    (wr_addr),
        .wr_data (s_data),
        .rd_en   (hit),
        .rd_bank (pixel_vpos[0]),
        .rd_x    (pixel_hpos[XW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_disp_line_buffer.sv
// Self-checking bench for disp_line_buffer (H_DISP=8, V_DISP=4) against a line-level reference model.
module tb_disp_line_buffer;

    localparam int          H  = 8;
    localparam int          V  = 4;
    localparam logic [23:0] UC = 24'hA5A5A5;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic [11:0] pixel_hpos;
    logic [11:0] pixel_vpos;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        underrun;
`ifdef DISP_LB_STATS_EN
    logic [15:0] underrun_cnt;
`endif

    disp_line_buffer #(
        .H_DISP         (H),
        .V_DISP         (V),
        .DW             (24),
        .PW             (12),
        .UNDERRUN_COLOR (UC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .pixel_hpos   (pixel_hpos),
        .pixel_vpos   (pixel_vpos),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .underrun     (underrun)
`ifdef DISP_LB_STATS_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    beat_t       q[$];
    bit          gap_en;

    // reference model: which line each slot holds (-1 = none), and the picture as written
    int          held [2];
    logic [23:0] img [V][H];
    bit          in_frame;
    int          wline, wx, vprev, e_cnt;
    logic        e_valid, e_under;
    logic [23:0] e_data;
    logic [23:0] sof_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held[0] = -1; held[1] = -1;
        in_frame = 1'b0; wline = 0; wx = 0; vprev = 4095;
        e_valid = 1'b0; e_under = 1'b0; e_data = '0; e_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_pixel_data", pixel_data, 0);
        chk("rst_underrun", underrun, 0);
`ifdef DISP_LB_STATS_EN
        chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        int h, v;
        bit rdy, act, hit;
        logic n_valid, n_under;
        logic [23:0] n_data;
        int n_cnt;
        beat_t b;
        if (q.size() != 0) begin
            s_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = q[0].d;
            s_sof   = q[0].sof;
        end else begin
            s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
        end
        #1;
        h = int'(pixel_hpos);
        v = int'(pixel_vpos);
        rdy = in_frame ? (held[wline % 2] < 0) : (!s_sof || held[0] < 0);
        chk("s_ready", s_ready, rdy);
        act = (h < H) && (v < V);
        hit = act && (held[v % 2] == v);
        n_valid = hit;
        n_under = act && !hit;
        if (hit)      n_data = img[v][h];
        else if (act) n_data = UC;
        else          n_data = '0;
        n_cnt = (e_under && e_cnt < 65535) ? e_cnt + 1 : e_cnt;
        if (vprev != v && vprev < V) held[vprev % 2] = -1;
        if (s_valid && rdy) begin
            b = q.pop_front();
            if (b.sof) begin
                if (in_frame) begin held[0] = -1; held[1] = -1; end
                img[0][0] = b.d; wline = 0; wx = 1; in_frame = 1'b1;
            end else if (in_frame) begin
                img[wline][wx] = b.d;
                if (wx == H - 1) begin
                    held[wline % 2] = wline;
                    wx = 0;
                    if (wline == V - 1) in_frame = 1'b0;
                    wline++;
                end else begin
                    wx++;
                end
            end
        end
        vprev = v;
        @(posedge clk);
        #1;
        e_valid = n_valid; e_under = n_under; e_data = n_data; e_cnt = n_cnt;
        chk("pixel_valid", pixel_valid, e_valid);
        chk("pixel_data", pixel_data, e_data);
        chk("underrun", underrun, e_under);
`ifdef DISP_LB_STATS_EN
        chk("underrun_cnt", underrun_cnt, e_cnt);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_empty(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic push(input logic [23:0] d, input logic sof);
        beat_t b;
        b.d = d; b.sof = sof;
        q.push_back(b);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        pixel_hpos = 12'd8; pixel_vpos = 12'd0; gap_en = 1'b0;
        model_reset();

        do_reset();

        // full frame, data = 16*line + x; both banks fill, then the writer stalls
        for (int l = 0; l < V; l++)
            for (int x = 0; x < H; x++)
                push(24'(16 * l + x), (l == 0 && x == 0));
        run(20);
        chk("stall_after_16", s_ready, 0);
        pixel_hpos = 12'd5; pixel_vpos = 12'd0;
        tick();
        chk("hit_5_0_valid", pixel_valid, 1);
        chk("hit_5_0_data", pixel_data, 24'h05);
        chk("hit_5_0_underrun", underrun, 0);

        // leaving line 0 frees bank 0 for line 2
        pixel_hpos = 12'd8; pixel_vpos = 12'd1;
        tick();
        chk("ready_after_release", s_ready, 1);
        run(8);
        pixel_hpos = 12'd3; pixel_vpos = 12'd2;
        tick();
        chk("hit_3_2_valid", pixel_valid, 1);
        chk("hit_3_2_data", pixel_data, 24'h23);

        // line 3 not yet complete
        pixel_hpos = 12'd2; pixel_vpos = 12'd3;
        tick();
        chk("miss_2_3_valid", pixel_valid, 0);
        chk("miss_2_3_data", pixel_data, UC);
        chk("miss_2_3_underrun", underrun, 1);
        pixel_hpos = 12'd8;
        tick();
`ifdef DISP_LB_STATS_EN
        chk("cnt_after_one_underrun", underrun_cnt, 1);
`endif
        run_until_empty(40);

        // resync: sof arrives at line 2, x 4
        sof_d = 24'($urandom);
        push(24'($urandom), 1'b1);
        for (int i = 0; i < 7 + 8 + 4; i++) push(24'($urandom), 1'b0);
        push(sof_d, 1'b1);
        for (int i = 0; i < 7; i++) push(24'($urandom), 1'b0);
        pixel_vpos = 12'd0;
        run(24);
        pixel_vpos = 12'd1;
        run_until_empty(40);
        pixel_hpos = 12'd0; pixel_vpos = 12'd0;
        tick();
        chk("resync_hit_valid", pixel_valid, 1);
        chk("resync_hit_data", pixel_data, sof_d);
        pixel_hpos = 12'd1; pixel_vpos = 12'd1;
        tick();
        chk("resync_old_line1_valid", pixel_valid, 0);
        chk("resync_old_line1_underrun", underrun, 1);

        // random traffic with gaps, frame restarts and wandering requests
        gap_en = 1'b1;
        pixel_hpos = 12'd8;
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && $urandom_range(0, 7) == 0) begin
                for (int k = 0; k < H * V; k++) push(24'($urandom), (k == 0));
            end
            if ($urandom_range(0, 7) == 0) pixel_vpos = 12'($urandom_range(0, V));
            pixel_hpos = 12'($urandom_range(0, H + 1));
            tick();
        end

        // non-sof beats in IDLE are swallowed and never become visible
        gap_en = 1'b0;
        pixel_hpos = 12'd8; pixel_vpos = 12'd0;
        do_reset();
        for (int i = 0; i < 5; i++) push(24'($urandom), 1'b0);
        run_until_empty(8);
        pixel_hpos = 12'd0;
        tick();
        chk("idle_discard_valid", pixel_valid, 0);
        chk("idle_discard_underrun", underrun, 1);
        chk("idle_discard_data", pixel_data, UC);
`ifdef DISP_LB_STATS_EN
        run(70000);
        chk("cnt_saturated", underrun_cnt, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
